// File: rtl/menu_pkg.sv
// -----------------------------------------------------------------------------
// menu_pkg
// Shared definitions for the battle-menu selection controller:
//   - menu item index constants (FIGHT, ACT, ITEM, MERCY)
//   - cursor index width POS_W
//   - FSM state type for menu_select
//   - wrapping cursor step helpers
// -----------------------------------------------------------------------------
package menu_pkg;

  localparam int unsigned POS_W = 2;

  localparam logic [POS_W-1:0] MENU_FIGHT = 2'd0;
  localparam logic [POS_W-1:0] MENU_ACT   = 2'd1;
  localparam logic [POS_W-1:0] MENU_ITEM  = 2'd2;
  localparam logic [POS_W-1:0] MENU_MERCY = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BROWSE   = 2'd1,
    COMMIT   = 2'd2,
    WAIT_ACK = 2'd3
  } menu_state_t;

  // Step the cursor forward, wrapping from the last item back to the first.
  function automatic logic [POS_W-1:0] pos_next(input logic [POS_W-1:0] pos,
                                                input int unsigned     n_items);
    if (pos >= POS_W'(n_items - 1)) return '0;
    else                            return pos + POS_W'(1);
  endfunction

  // Step the cursor backward, wrapping from the first item to the last.
  function automatic logic [POS_W-1:0] pos_prev(input logic [POS_W-1:0] pos,
                                                input int unsigned     n_items);
    if (pos == '0) return POS_W'(n_items - 1);
    else           return pos - POS_W'(1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// One raw push-button path: 2-flop synchronizer, stability-count debouncer and
// registered rising-edge detector producing a one-cycle press event.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous, active-high reset
//   btn   in   raw button, active-high, asynchronous to clk
//   press out  one-cycle pulse on each debounced press (release gives none)
// -----------------------------------------------------------------------------
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_a;
  logic             sync_b;
  logic             state;
  logic             state_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
    end
  end

  // The counter tracks how long the synchronized input has disagreed with the
  // debounced state; the state flips only on the sample after it saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= 1'b0;
      cnt   <= '0;
    end else if (sync_b == state) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
      state <= ~state;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      state_q <= state;
      press   <= state & ~state_q;
    end
  end

endmodule

// File: rtl/menu_select.sv
// -----------------------------------------------------------------------------
// menu_select
// Battle-menu selection controller. Debounces left/right/confirm buttons,
// keeps a wrapping cursor over the menu items, emits a one-cycle selection
// pulse on confirm and locks until game logic acknowledges.
// Ports:
//   i_clk             in   system clock
//   i_reset           in   asynchronous, active-high reset
//   i_btn_left        in   raw left button
//   i_btn_right       in   raw right button
//   i_btn_confirm     in   raw confirm button
//   i_enable          in   high while it is the player's menu turn
//   i_ack             in   game logic finished the selected action
//   o_cursor_position out  current cursor index
//   o_selected        out  index captured at confirm, held until next confirm
//   o_select_valid    out  one-cycle pulse, o_selected valid in that cycle
//   o_busy            out  high from the select pulse until ack accepted
// -----------------------------------------------------------------------------
module menu_select
  import menu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned N_ITEMS         = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_btn_left,
  input  logic             i_btn_right,
  input  logic             i_btn_confirm,
  input  logic             i_enable,
  input  logic             i_ack,
  output logic [POS_W-1:0] o_cursor_position,
  output logic [POS_W-1:0] o_selected,
  output logic             o_select_valid,
  output logic             o_busy
);

  logic        ev_left;
  logic        ev_right;
  logic        ev_confirm;
  menu_state_t state;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk   (i_clk),
    .rst   (i_reset),
    .btn   (i_btn_left),
    .press (ev_left)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk   (i_clk),
    .rst   (i_reset),
    .btn   (i_btn_right),
    .press (ev_right)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_confirm (
    .clk   (i_clk),
    .rst   (i_reset),
    .btn   (i_btn_confirm),
    .press (ev_confirm)
  );

  // Events outside BROWSE are simply not looked at, so they are dropped.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state             <= IDLE;
      o_cursor_position <= '0;
      o_selected        <= '0;
      o_select_valid    <= 1'b0;
      o_busy            <= 1'b0;
    end else begin
      o_select_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_enable) state <= BROWSE;
        end
        BROWSE: begin
          if (!i_enable) begin
            state <= IDLE;
          end else if (ev_confirm) begin
            // Confirm wins over any same-cycle move and captures the
            // pre-move cursor.
            o_selected     <= o_cursor_position;
            o_select_valid <= 1'b1;
            o_busy         <= 1'b1;
            state          <= COMMIT;
          end else if (ev_left && !ev_right) begin
            o_cursor_position <= pos_prev(o_cursor_position, N_ITEMS);
          end else if (ev_right && !ev_left) begin
            o_cursor_position <= pos_next(o_cursor_position, N_ITEMS);
          end
        end
        COMMIT: begin
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (i_ack) begin
            o_busy <= 1'b0;
            state  <= i_enable ? BROWSE : IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_menu_select.sv
// -----------------------------------------------------------------------------
// tb_menu_select
// Self-checking bench for menu_select with DEBOUNCE_CYCLES = 4. A reference
// model tracks raw button history with a sliding window and the menu rules
// with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_menu_select;

  localparam int D = 4;
  localparam logic [31:0] MASK = (32'd1 << (D + 1)) - 32'd1;

  localparam int M_IDLE   = 0;
  localparam int M_BROWSE = 1;
  localparam int M_COMMIT = 2;
  localparam int M_WAIT   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_confirm = 1'b0;
  logic       enable = 1'b0;
  logic       ack = 1'b0;
  logic [1:0] cursor;
  logic [1:0] selected;
  logic       select_valid;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  menu_select #(.DEBOUNCE_CYCLES(D), .N_ITEMS(4)) dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_btn_left        (btn_left),
    .i_btn_right       (btn_right),
    .i_btn_confirm     (btn_confirm),
    .i_enable          (enable),
    .i_ack             (ack),
    .o_cursor_position (cursor),
    .o_selected        (selected),
    .o_select_valid    (select_valid),
    .o_busy            (busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_hist [3];
  logic [2:0]  m_db;
  logic [2:0]  m_dbq;
  logic [2:0]  m_ev;
  int          m_mode;
  int          m_cur;
  int          m_sel;
  logic        m_valid;
  logic        m_busy;
  logic [2:0]  raw_now;

  assign raw_now = {btn_confirm, btn_right, btn_left};
  assign m_busy  = (m_mode == M_COMMIT) || (m_mode == M_WAIT);

  // A debounced level flips once the last D+1 synchronized samples (raw input
  // two edges old) all disagree with it; an event is its rise, one edge later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 3; b++) m_hist[b] <= '0;
      m_db    <= '0;
      m_dbq   <= '0;
      m_ev    <= '0;
      m_mode  <= M_IDLE;
      m_cur   <= 0;
      m_sel   <= 0;
      m_valid <= 1'b0;
    end else begin
      for (int b = 0; b < 3; b++) begin
        if ((!m_db[b] && (((m_hist[b] >> 1) & MASK) == MASK)) ||
            ( m_db[b] && (((m_hist[b] >> 1) & MASK) == 32'd0)))
          m_db[b] <= ~m_db[b];
        m_hist[b] <= {m_hist[b][30:0], raw_now[b]};
      end
      m_dbq   <= m_db;
      m_ev    <= m_db & ~m_dbq;
      m_valid <= 1'b0;
      case (m_mode)
        M_IDLE:   if (enable) m_mode <= M_BROWSE;
        M_BROWSE: begin
          if (!enable) m_mode <= M_IDLE;
          else if (m_ev[2]) begin
            m_sel   <= m_cur;
            m_valid <= 1'b1;
            m_mode  <= M_COMMIT;
          end else if (m_ev[0] != m_ev[1]) begin
            m_cur <= m_ev[1] ? (m_cur + 1) % 4 : (m_cur + 3) % 4;
          end
        end
        M_COMMIT: m_mode <= M_WAIT;
        default:  if (ack) m_mode <= enable ? M_BROWSE : M_IDLE;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: btn_left = v;
      1: btn_right = v;
      default: btn_confirm = v;
    endcase
  endtask

  // Hold one button for len cycles, then leave time for release to settle.
  task automatic press(input int which, input int len);
    set_btn(which, 1'b1);
    idle(len);
    set_btn(which, 1'b0);
    idle(12);
  endtask

  task automatic pulse_ack;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    n_checks++; if (cursor !== 2'd0) begin n_fail++; $display("FAIL reset_cursor: got %0d expected 0", cursor); end
    n_checks++; if (selected !== 2'd0) begin n_fail++; $display("FAIL reset_selected: got %0d expected 0", selected); end
    n_checks++; if (select_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", select_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_wrap;
    logic [1:0] exp_pos [4];
    exp_pos = '{2'd1, 2'd2, 2'd3, 2'd0};
    enable = 1'b1;
    idle(2);
    for (int i = 0; i < 4; i++) begin
      press(1, 6);
      n_checks++; if (cursor !== exp_pos[i]) begin n_fail++; $display("FAIL wrap_right%0d: got %0d expected %0d", i, cursor, exp_pos[i]); end
    end
    press(0, 6);
    n_checks++; if (cursor !== 2'd3) begin n_fail++; $display("FAIL wrap_left: got %0d expected 3", cursor); end
  endtask

  task automatic test_glitch;
    int got;
    press(1, 3);
    n_checks++; if (cursor !== 2'd3) begin n_fail++; $display("FAIL glitch_short: got %0d expected 3", cursor); end
    got = -1;
    btn_right = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 6) btn_right = 1'b0;
      if (got < 0 && cursor !== 2'd3) got = i;
    end
    n_checks++; if (got != 9) begin n_fail++; $display("FAIL move_latency: got %0d expected 9", got); end
    n_checks++; if (cursor !== 2'd0) begin n_fail++; $display("FAIL six_cycle_move: got %0d expected 0", cursor); end
    press(1, 100);
    n_checks++; if (cursor !== 2'd1) begin n_fail++; $display("FAIL hold_no_repeat: got %0d expected 1", cursor); end
  endtask

  task automatic test_confirm;
    int nvalid;
    int vat;
    press(1, 6);
    n_checks++; if (cursor !== 2'd2) begin n_fail++; $display("FAIL pre_confirm_cursor: got %0d expected 2", cursor); end
    nvalid = 0;
    vat = -1;
    btn_confirm = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 6) btn_confirm = 1'b0;
      if (select_valid === 1'b1) begin
        nvalid++;
        vat = i;
        n_checks++; if (selected !== 2'd2) begin n_fail++; $display("FAIL confirm_selected: got %0d expected 2", selected); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL confirm_busy: got %b expected 1", busy); end
      end
    end
    n_checks++; if (nvalid != 1) begin n_fail++; $display("FAIL valid_width: got %0d expected 1", nvalid); end
    n_checks++; if (vat != 9) begin n_fail++; $display("FAIL valid_latency: got %0d expected 9", vat); end
    press(1, 6);
    press(1, 6);
    n_checks++; if (cursor !== 2'd2) begin n_fail++; $display("FAIL wait_ack_locked: got %0d expected 2", cursor); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wait_ack_busy: got %b expected 1", busy); end
    pulse_ack();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ack_busy: got %b expected 0", busy); end
    idle(1);
    press(1, 6);
    n_checks++; if (cursor !== 2'd3) begin n_fail++; $display("FAIL after_ack_move: got %0d expected 3", cursor); end
  endtask

  task automatic test_coincident;
    int nvalid;
    btn_left = 1'b1;
    btn_right = 1'b1;
    idle(6);
    btn_left = 1'b0;
    btn_right = 1'b0;
    idle(12);
    n_checks++; if (cursor !== 2'd3) begin n_fail++; $display("FAIL left_right_cancel: got %0d expected 3", cursor); end
    press(1, 6);
    press(1, 6);
    nvalid = 0;
    btn_confirm = 1'b1;
    btn_right = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 6) begin btn_confirm = 1'b0; btn_right = 1'b0; end
      if (select_valid === 1'b1) begin
        nvalid++;
        n_checks++; if (selected !== 2'd1) begin n_fail++; $display("FAIL coincident_selected: got %0d expected 1", selected); end
      end
    end
    n_checks++; if (nvalid != 1) begin n_fail++; $display("FAIL coincident_valid: got %0d expected 1", nvalid); end
    n_checks++; if (cursor !== 2'd1) begin n_fail++; $display("FAIL coincident_cursor: got %0d expected 1", cursor); end
    pulse_ack();
    idle(1);
  endtask

  task automatic test_enable;
    press(1, 6);
    press(1, 6);
    n_checks++; if (cursor !== 2'd3) begin n_fail++; $display("FAIL enable_setup: got %0d expected 3", cursor); end
    enable = 1'b0;
    idle(2);
    press(1, 6);
    press(0, 6);
    n_checks++; if (cursor !== 2'd3) begin n_fail++; $display("FAIL disabled_ignored: got %0d expected 3", cursor); end
    enable = 1'b1;
    idle(2);
    press(2, 6);
    n_checks++; if (selected !== 2'd3) begin n_fail++; $display("FAIL reenable_select: got %0d expected 3", selected); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reenable_busy: got %b expected 1", busy); end
    enable = 1'b0;
    pulse_ack();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ack_disabled_busy: got %b expected 0", busy); end
    press(1, 6);
    n_checks++; if (cursor !== 2'd3) begin n_fail++; $display("FAIL ack_to_idle: got %0d expected 3", cursor); end
    enable = 1'b1;
    idle(2);
    press(1, 6);
    n_checks++; if (cursor !== 2'd0) begin n_fail++; $display("FAIL idle_to_browse: got %0d expected 0", cursor); end
  endtask

  task automatic test_async_reset;
    press(1, 6);
    press(2, 6);
    n_checks++; if (busy !== 1'b1 || selected !== 2'd1) begin n_fail++; $display("FAIL pre_reset_state: got busy=%b sel=%0d expected busy=1 sel=1", busy, selected); end
    btn_right = 1'b1;
    idle(3);
    #3 rst = 1'b1;
    #1;
    n_checks++; if ({cursor, selected, select_valid, busy} !== 6'd0) begin n_fail++; $display("FAIL async_reset_outputs: got cur=%0d sel=%0d v=%b busy=%b expected all 0", cursor, selected, select_valid, busy); end
    btn_right = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(20);
    n_checks++; if (cursor !== 2'd0) begin n_fail++; $display("FAIL no_spurious_event: got %0d expected 0", cursor); end
    btn_right = 1'b1;
    idle(2);
    #3 rst = 1'b1;
    @(negedge clk);
    idle(2);
    rst = 1'b0;
    idle(15);
    btn_right = 1'b0;
    n_checks++; if (cursor !== 2'd1) begin n_fail++; $display("FAIL held_through_reset: got %0d expected 1", cursor); end
    idle(12);
    n_checks++; if (cursor !== m_cur[1:0]) begin n_fail++; $display("FAIL model_sync_after_reset: got %0d expected %0d", cursor, m_cur); end
  endtask

  task automatic test_random;
    int run [3];
    for (int b = 0; b < 3; b++) run[b] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      n_checks++; if (cursor !== m_cur[1:0]) begin n_fail++; $display("FAIL rnd_cursor @%0d: got %0d expected %0d", c, cursor, m_cur); end
      n_checks++; if (selected !== m_sel[1:0]) begin n_fail++; $display("FAIL rnd_selected @%0d: got %0d expected %0d", c, selected, m_sel); end
      n_checks++; if (select_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid @%0d: got %b expected %b", c, select_valid, m_valid); end
      n_checks++; if (busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy @%0d: got %b expected %b", c, busy, m_busy); end
      for (int b = 0; b < 3; b++) begin
        if (run[b] == 0) begin
          set_btn(b, 1'($urandom_range(0, 1)));
          run[b] = $urandom_range(1, 10);
        end
        run[b]--;
      end
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      ack = ($urandom_range(0, 7) == 0);
    end
    ack = 1'b0;
    btn_left = 1'b0;
    btn_right = 1'b0;
    btn_confirm = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_wrap();
    test_glitch();
    test_confirm();
    test_coincident();
    test_enable();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
